// File: rtl/mem_bus_if.sv
// Bus access unit behind the mem stage: loads are one RIB read, stores are a
// read of the target word, a one-cycle merge slot, then the merged write.
module mem_bus_if #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] raddr_i,
    input  logic [31:0] waddr_i,
    input  logic [31:0] wdata_i,
    input  logic        int_assert_i,
    output logic [31:0] rdata_o,
    output logic        hold_o,
    output logic        err_o,
    output logic        rib_req_o,
    output logic        rib_we_o,
    output logic [31:0] rib_addr_o,
    output logic [31:0] rib_wdata_o,
    input  logic        rib_ack_i,
    input  logic [31:0] rib_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_MERGE,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic              rib_req_q, rib_req_d;
    logic              rib_we_q, rib_we_d;
    logic [31:0]       rib_addr_q, rib_addr_d;
    logic [31:0]       rib_wdata_q, rib_wdata_d;
    logic [31:0]       data_q, data_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              ack;
    logic              timeout;

    // An ack only counts while a request is actually on the bus.
    assign ack     = rib_ack_i && rib_req_q;
    assign timeout = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rib_req_q   <= 1'b0;
            rib_we_q    <= 1'b0;
            rib_addr_q  <= '0;
            rib_wdata_q <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rib_req_q   <= rib_req_d;
            rib_we_q    <= rib_we_d;
            rib_addr_q  <= rib_addr_d;
            rib_wdata_q <= rib_wdata_d;
            data_q      <= data_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rib_req_d   = rib_req_q;
        rib_we_d    = rib_we_q;
        rib_addr_d  = rib_addr_q;
        rib_wdata_d = rib_wdata_q;
        data_d      = data_q;
        err_d       = 1'b0;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (req_i && !int_assert_i) begin
                    rib_req_d  = 1'b1;
                    rib_we_d   = 1'b0;
                    rib_addr_d = we_i ? waddr_i : raddr_i;
                    cnt_d      = '0;
                    state_d    = S_RD;
                end
            end

            S_RD: begin
                if (ack) begin
                    data_d    = rib_rdata_i;
                    rib_req_d = 1'b0;
                    state_d   = (we_i && !int_assert_i) ? S_MERGE : S_DONE;
                end else if (timeout) begin
                    rib_req_d = 1'b0;
                    data_d    = '0;
                    err_d     = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // rdata_o carries the old word here so the mem stage can merge wdata_i.
            S_MERGE: begin
                if (int_assert_i) begin
                    state_d = S_DONE;
                end else begin
                    rib_req_d   = 1'b1;
                    rib_we_d    = 1'b1;
                    rib_addr_d  = waddr_i;
                    rib_wdata_d = wdata_i;
                    cnt_d       = '0;
                    state_d     = S_WR;
                end
            end

            S_WR: begin
                if (ack) begin
                    rib_req_d = 1'b0;
                    rib_we_d  = 1'b0;
                    state_d   = S_DONE;
                end else if (timeout) begin
                    rib_req_d = 1'b0;
                    rib_we_d  = 1'b0;
                    err_d     = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign hold_o      = req_i && (state_q != S_DONE) &&
                         !((state_q == S_IDLE) && int_assert_i);
    assign rdata_o     = data_q;
    assign err_o       = err_q;
    assign rib_req_o   = rib_req_q;
    assign rib_we_o    = rib_we_q;
    assign rib_addr_o  = rib_addr_q;
    assign rib_wdata_o = rib_wdata_q;

endmodule

// File: tb/tb_mem_bus_if.sv
// Directed bench for mem_bus_if: table of load/store accesses against a small
// bus responder, plus interrupt-in-IDLE and reset-during-write sequences.
module tb_mem_bus_if;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] raddr_i = '0;
    logic [31:0] waddr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        int_assert_i = 1'b0;
    logic [31:0] rdata_o;
    logic        hold_o;
    logic        err_o;
    logic        rib_req_o;
    logic        rib_we_o;
    logic [31:0] rib_addr_o;
    logic [31:0] rib_wdata_o;
    logic        rib_ack_i = 1'b0;
    logic [31:0] rib_rdata_i = '0;

    always #5 clk = ~clk;

    mem_bus_if #(.TIMEOUT_CYCLES(255), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .we_i         (we_i),
        .raddr_i      (raddr_i),
        .waddr_i      (waddr_i),
        .wdata_i      (wdata_i),
        .int_assert_i (int_assert_i),
        .rdata_o      (rdata_o),
        .hold_o       (hold_o),
        .err_o        (err_o),
        .rib_req_o    (rib_req_o),
        .rib_we_o     (rib_we_o),
        .rib_addr_o   (rib_addr_o),
        .rib_wdata_o  (rib_wdata_o),
        .rib_ack_i    (rib_ack_i),
        .rib_rdata_i  (rib_rdata_i)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%08h", name, act);
        end
    endtask

    // int_mode: 0 none, 1 interrupt during RD, 2 interrupt during MERGE
    typedef struct {
        logic        we;
        logic [31:0] raddr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] rword;
        int          rd_dly;
        int          wr_dly;
        int          int_mode;
        int          exp_cycles;
        int          exp_hold;
        logic [31:0] exp_rdata;
        int          exp_write;
        int          exp_err;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [31:0] raddr, input logic [31:0] waddr,
                                input logic [31:0] wdata, input logic [31:0] rword,
                                input int rd_dly, input int wr_dly, input int int_mode,
                                input int exp_cycles, input int exp_hold,
                                input logic [31:0] exp_rdata, input int exp_write, input int exp_err);
        vec_t v;
        v.we = we; v.raddr = raddr; v.waddr = waddr; v.wdata = wdata; v.rword = rword;
        v.rd_dly = rd_dly; v.wr_dly = wr_dly; v.int_mode = int_mode;
        v.exp_cycles = exp_cycles; v.exp_hold = exp_hold; v.exp_rdata = exp_rdata;
        v.exp_write = exp_write; v.exp_err = exp_err;
        return v;
    endfunction

    // Runs one access from its IDLE cycle through DONE (first cycle with hold_o low).
    task automatic run_access(input vec_t v, output int cycles, output int hold_cnt,
                              output int rd_bad, output int wr_bad, output int wr_cycles,
                              output int err_cnt, output int post_ack_req, output logic idle_req,
                              output logic [31:0] done_rdata, output logic done_req,
                              output logic finished);
        int          rd_wait;
        int          wr_wait;
        logic        prev_ack;
        logic        prev_rd_ack;
        logic [31:0] exp_ra;
        rd_wait = 0; wr_wait = 0; prev_ack = 1'b0; prev_rd_ack = 1'b0;
        rd_bad = 0; wr_bad = 0; wr_cycles = 0; post_ack_req = 0;
        done_rdata = '0; done_req = 1'b0; finished = 1'b0;
        exp_ra = v.we ? v.waddr : v.raddr;

        @(posedge clk); #1;
        req_i = 1'b1; we_i = v.we; raddr_i = v.raddr; waddr_i = v.waddr;
        wdata_i = ~v.wdata; int_assert_i = 1'b0; rib_ack_i = 1'b0; rib_rdata_i = 32'hBAD0_0000;
        #1;
        idle_req = rib_req_o;
        cycles   = 1;
        hold_cnt = int'(hold_o);
        err_cnt  = int'(err_o);

        for (int c = 0; c < 400 && !finished; c++) begin
            @(posedge clk); #1;
            if (prev_ack) post_ack_req += int'(rib_req_o);
            rib_ack_i = 1'b0; rib_rdata_i = $urandom; wdata_i = ~v.wdata; int_assert_i = 1'b0;
            if (prev_rd_ack) begin
                wdata_i = v.wdata;
                if (v.int_mode == 2) int_assert_i = 1'b1;
                if (!rib_req_o) rib_ack_i = 1'b1;
            end
            prev_ack = 1'b0; prev_rd_ack = 1'b0;
            if (rib_req_o && !rib_we_o) begin
                if (rib_addr_o !== exp_ra) rd_bad++;
                if (v.int_mode == 1) int_assert_i = 1'b1;
                if (rd_wait == v.rd_dly) begin
                    rib_ack_i = 1'b1; rib_rdata_i = v.rword;
                    prev_ack = 1'b1; prev_rd_ack = 1'b1;
                end
                rd_wait++;
            end else if (rib_req_o && rib_we_o) begin
                wr_cycles++;
                if (rib_addr_o !== v.waddr || rib_wdata_o !== v.wdata) wr_bad++;
                if (wr_wait == v.wr_dly) begin
                    rib_ack_i = 1'b1; prev_ack = 1'b1;
                end
                wr_wait++;
            end
            #1;
            cycles++;
            hold_cnt += int'(hold_o);
            err_cnt  += int'(err_o);
            if (!hold_o) begin
                done_rdata = rdata_o;
                done_req   = rib_req_o;
                finished   = 1'b1;
            end
        end
        rib_ack_i = 1'b0;
        int_assert_i = 1'b0;
    endtask

    task automatic apply_vec(input string tag, input vec_t v);
        int cycles, hold_cnt, rd_bad, wr_bad, wr_cycles, err_cnt, post_ack_req;
        logic idle_req, done_req, finished;
        logic [31:0] done_rdata;
        run_access(v, cycles, hold_cnt, rd_bad, wr_bad, wr_cycles, err_cnt, post_ack_req,
                   idle_req, done_rdata, done_req, finished);
        check({tag, "_finished"},     32'(finished),        32'd1);
        check({tag, "_cycles"},       32'(cycles),          32'(v.exp_cycles));
        check({tag, "_hold_cycles"},  32'(hold_cnt),        32'(v.exp_hold));
        check({tag, "_idle_req"},     32'(idle_req),        32'd0);
        check({tag, "_rd_addr_bad"},  32'(rd_bad),          32'd0);
        check({tag, "_wr_bad"},       32'(wr_bad),          32'd0);
        check({tag, "_write_issued"}, 32'(wr_cycles > 0),   32'(v.exp_write));
        check({tag, "_err_pulses"},   32'(err_cnt),         32'(v.exp_err));
        check({tag, "_req_after_ack"},32'(post_ack_req),    32'd0);
        check({tag, "_done_req"},     32'(done_req),        32'd0);
        check({tag, "_rdata"},        done_rdata,           v.exp_rdata);
    endtask

    vec_t vecs[9];
    logic in_wr;

    initial begin
        vecs[0] = mk(1'b0, 32'h0000_0100, 32'h0,         32'h0,         32'h1122_3344, 0,    0,    0, 3,   2,   32'h1122_3344, 0, 0);
        vecs[1] = mk(1'b0, 32'h0000_0ABC, 32'h0,         32'h0,         32'hDEAD_BEEF, 2,    0,    0, 5,   4,   32'hDEAD_BEEF, 0, 0);
        vecs[2] = mk(1'b1, 32'h0000_0999, 32'h0000_0204, 32'hCAFE_F00D, 32'h5566_7788, 3,    3,    0, 11,  10,  32'h5566_7788, 1, 0);
        vecs[3] = mk(1'b1, 32'h0000_0000, 32'h0000_03F0, 32'h0000_00A5, 32'h1234_5678, 0,    0,    0, 5,   4,   32'h1234_5678, 1, 0);
        vecs[4] = mk(1'b1, 32'h0000_0000, 32'h0000_0410, 32'h1111_2222, 32'hA5A5_A5A5, 1,    0,    1, 4,   3,   32'hA5A5_A5A5, 0, 0);
        vecs[5] = mk(1'b1, 32'h0000_0000, 32'h0000_0420, 32'h3333_4444, 32'h0F0F_0F0F, 0,    0,    2, 4,   3,   32'h0F0F_0F0F, 0, 0);
        vecs[6] = mk(1'b0, 32'h0000_0800, 32'h0,         32'h0,         32'hFFFF_FFFF, 1000, 0,    0, 257, 256, 32'h0000_0000, 0, 1);
        vecs[7] = mk(1'b1, 32'h0000_0000, 32'h0000_0900, 32'h5A5A_0000, 32'h7777_7777, 0,    1000, 0, 259, 258, 32'h7777_7777, 1, 1);
        vecs[8] = mk(1'b0, 32'h0000_0040, 32'h0,         32'h0,         32'h89AB_CDEF, 1,    0,    0, 4,   3,   32'h89AB_CDEF, 0, 0);

        // Reset state
        #2;
        check("rst_rib_req",   32'(rib_req_o), 32'd0);
        check("rst_rib_we",    32'(rib_we_o),  32'd0);
        check("rst_rib_addr",  rib_addr_o,     32'd0);
        check("rst_rib_wdata", rib_wdata_o,    32'd0);
        check("rst_rdata",     rdata_o,        32'd0);
        check("rst_err",       32'(err_o),     32'd0);
        check("rst_hold",      32'(hold_o),    32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Back-to-back accesses: req_i stays high from one access into the next
        for (int i = 0; i < 9; i++) begin
            apply_vec($sformatf("v%0d", i), vecs[i]);
        end

        // Interrupt in IDLE with a pending request: nothing issued, no stall
        @(posedge clk); #1;
        req_i = 1'b1; we_i = 1'b0; raddr_i = 32'h0000_0700; int_assert_i = 1'b1;
        #1;
        check("int_idle_hold", 32'(hold_o),    32'd0);
        check("int_idle_req",  32'(rib_req_o), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #2;
            check($sformatf("int_idle_req_c%0d", c),  32'(rib_req_o), 32'd0);
            check($sformatf("int_idle_hold_c%0d", c), 32'(hold_o),    32'd0);
        end
        @(posedge clk); #1;
        req_i = 1'b0; int_assert_i = 1'b0;

        // Asynchronous reset while the write phase of a store is on the bus
        @(posedge clk); #1;
        req_i = 1'b1; we_i = 1'b1; raddr_i = '0; waddr_i = 32'h0000_0500;
        wdata_i = 32'h600D_F00D; rib_ack_i = 1'b0;
        in_wr = 1'b0;
        for (int c = 0; c < 20 && !in_wr; c++) begin
            @(posedge clk); #1;
            rib_ack_i   = rib_req_o && !rib_we_o;
            rib_rdata_i = 32'h0000_1234;
            in_wr       = rib_req_o && rib_we_o;
        end
        rib_ack_i = 1'b0;
        check("arst_reached_wr", 32'(in_wr), 32'd1);
        #4;
        rst = 1'b0;
        #1;
        check("arst_rib_req",   32'(rib_req_o), 32'd0);
        check("arst_rib_we",    32'(rib_we_o),  32'd0);
        check("arst_rib_addr",  rib_addr_o,     32'd0);
        check("arst_rdata",     rdata_o,        32'd0);
        req_i = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            rib_ack_i = 1'b1;
            #1;
            check($sformatf("post_rst_req_c%0d", c), 32'(rib_req_o), 32'd0);
            check($sformatf("post_rst_we_c%0d", c),  32'(rib_we_o),  32'd0);
        end
        rib_ack_i = 1'b0;
        apply_vec("post_rst_load", mk(1'b0, 32'h0000_0C00, 32'h0, 32'h0, 32'h2468_ACE0,
                                      0, 0, 0, 3, 2, 32'h2468_ACE0, 0, 0));

        @(posedge clk); #1;
        req_i = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
